fft_frame_sequencer: RTL and testbench

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

---
 rtl/fft_seq_pkg.sv | 32 +++
 rtl/fft_seq_downcnt.sv | 27 ++
 rtl/fft_frame_sequencer.sv | 109 ++++++++++
 tb/tb_fft_frame_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// Shared types and lane helpers for the FFT frame sequencer.
// Lane k of a 64-bit bus occupies bits [8k+7:8k].
package fft_seq_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL
    } state_t;

    typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

    function automatic lanes_t unpack_lanes(input logic [LANES*LANE_W-1:0] bus);
        lanes_t l;
        for (int unsigned k = 0; k < LANES; k++) begin
            l[k] = bus[k*LANE_W +: LANE_W];
        end
        return l;
    endfunction

    function automatic logic [LANES*LANE_W-1:0] pack_lanes(input lanes_t l);
        logic [LANES*LANE_W-1:0] bus;
        for (int unsigned k = 0; k < LANES; k++) begin
            bus[k*LANE_W +: LANE_W] = l[k];
        end
        return bus;
    endfunction

endpackage

// File: rtl/fft_seq_downcnt.sv
// 4-bit loadable down-counter that saturates at zero and flags the zero state.
module fft_seq_downcnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic [3:0] o_cnt,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Issues one frame at a time to a fixed-latency FFT core, holds its inputs
// stable until the result is captured, and stalls when the consumer is not ready.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned GAP     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    fft_next,
    output logic [LANES*LANE_W-1:0] fft_x,
    input  logic [LANES*LANE_W-1:0] fft_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    lanes_t                  r_x;
    logic                    r_next;
    logic                    r_out_valid;
    logic [LANES*LANE_W-1:0] r_out_data;
    logic [15:0]             r_frame_cnt;

    logic [3:0] w_lat_cnt;
    logic       w_lat_zero;
    logic [3:0] w_gap_cnt;
    logic       w_gap_zero;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_cap_cond;
    logic       w_capture;

    fft_seq_downcnt u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (4'(LATENCY)),
        .i_en       ((r_state == WAIT) && !w_lat_zero),
        .o_cnt      (w_lat_cnt),
        .o_zero     (w_lat_zero)
    );

    fft_seq_downcnt u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (4'(GAP)),
        .i_en       (!w_gap_zero),
        .o_cnt      (w_gap_cnt),
        .o_zero     (w_gap_zero)
    );

    // in_ready depends on registered state only, never on in_valid.
    always_comb begin
        w_in_ready  = (r_state == IDLE) && (w_gap_cnt == '0);
        w_accept    = in_valid && w_in_ready;
        w_cap_cond  = ((r_state == WAIT) && (w_lat_cnt == 4'd1)) || (r_state == STALL);
        w_capture   = w_cap_cond && (!r_out_valid || out_ready);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = WAIT;
            WAIT:    if (w_lat_cnt == 4'd1) w_state_nxt = w_capture ? IDLE : STALL;
            STALL:   if (w_capture) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_next      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_next  <= w_accept;
            if (w_accept) begin
                r_x <= unpack_lanes(in_data);
            end
            // A capture on the same edge as a consumer handshake keeps out_valid high.
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= fft_y;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign fft_next  = r_next;
    assign fft_x     = pack_lanes(r_x);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != IDLE);
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a small combinational FFT core model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fft_frame_sequencer;
    import fft_seq_pkg::*;

    localparam logic [63:0] D1 = 64'h0706050403020100;
    localparam logic [63:0] D2 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] R1 = 64'hF800FCFC00F8100C;
    localparam logic [63:0] R2 = 64'hF800FCFC00F8302C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, fft_next, out_valid, out_ready, busy;
    logic [63:0] in_data, fft_x, fft_y, out_data;
    logic [15:0] frame_cnt;
    logic        in_valid2, in_ready2, fft_next2, out_valid2, out_ready2, busy2;
    logic [63:0] in_data2, fft_x2, fft_y2, out_data2;
    logic [15:0] frame_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two-stage butterfly core stub: a=x[k]+x[k+4], b=x[k]-x[k+4], 8-bit wrap.
    function automatic logic [63:0] core_model(input logic [63:0] x);
        logic [7:0] a [4];
        logic [7:0] b [4];
        logic [7:0] y [8];
        logic [63:0] r;
        for (int k = 0; k < 4; k++) begin
            a[k] = x[8*k +: 8] + x[8*(k+4) +: 8];
            b[k] = x[8*k +: 8] - x[8*(k+4) +: 8];
        end
        y[0] = a[0] + a[2];  y[1] = a[1] + a[3];
        y[2] = b[0] + b[1];  y[3] = b[0] - b[1];
        y[4] = a[0] - a[2];  y[5] = a[1] - a[3];
        y[6] = b[2] - b[3];  y[7] = b[2] + b[3];
        for (int k = 0; k < 8; k++) r[8*k +: 8] = y[k];
        return r;
    endfunction

    assign fft_y  = core_model(fft_x);
    assign fft_y2 = core_model(fft_x2);

    fft_frame_sequencer #(.LATENCY(2), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .fft_next(fft_next), .fft_x(fft_x), .fft_y(fft_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    fft_frame_sequencer #(.LATENCY(2), .GAP(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .fft_next(fft_next2), .fft_x(fft_x2), .fft_y(fft_y2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .frame_cnt(frame_cnt2)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = D1; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (fft_next !== 1'b0) begin errors++; $display("FAIL reset_fft_next got %b exp 0", fft_next); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt got %h exp 0", frame_cnt); end
        checks++; if (fft_x !== 64'h0) begin errors++; $display("FAIL reset_fft_x got %h exp 0", fft_x); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        in_valid = 1'b0; rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single_frame();
        in_valid = 1'b1; in_data = D1;
        step();
        in_valid = 1'b0;
        checks++; if (fft_next !== 1'b1) begin errors++; $display("FAIL single_next_hi got %b exp 1", fft_next); end
        checks++; if (fft_x !== D1) begin errors++; $display("FAIL single_fft_x got %h exp %h", fft_x, D1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_early1 got %b exp 0", out_valid); end
        step();
        checks++; if (fft_next !== 1'b0) begin errors++; $display("FAIL single_next_lo got %b exp 0", fft_next); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_early2 got %b exp 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_ov got %b exp 1", out_valid); end
        checks++; if (out_data !== R1) begin errors++; $display("FAIL single_data got %h exp %h", out_data, R1); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_clear got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int acc2;
        acc2 = -1;
        in_valid = 1'b1; in_data = D2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b exp 1", in_ready); end
        for (int c = 1; c <= 10; c++) begin
            step();
            if (in_ready === 1'b1) begin
                acc2 = c;
                break;
            end
        end
        checks++; if (acc2 != 3) begin errors++; $display("FAIL b2b_spacing got %0d exp 3", acc2); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_ov1 got %b exp 1", out_valid); end
        checks++; if (out_data !== R2) begin errors++; $display("FAIL b2b_data1 got %h exp %h", out_data, R2); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt1 got %0d exp 2", frame_cnt); end
        step();
        in_valid = 1'b0;
        checks++; if (fft_next !== 1'b1) begin errors++; $display("FAIL b2b_next got %b exp 1", fft_next); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_ov_clear got %b exp 0", out_valid); end
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_ov2 got %b exp 1", out_valid); end
        checks++; if (out_data !== R2) begin errors++; $display("FAIL b2b_data2 got %h exp %h", out_data, R2); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt2 got %0d exp 3", frame_cnt); end
        step();
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = D1; out_ready = 1'b1;
        step();
        in_data = D2;
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_ov_a got %b exp 1", out_valid); end
        checks++; if (out_data !== R1) begin errors++; $display("FAIL stall_data_a got %h exp %h", out_data, R1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready got %b exp 1", in_ready); end
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (fft_x !== D2) begin errors++; $display("FAIL stall_x_b got %h exp %h", fft_x, D2); end
        step(); step();
        checks++; if (dut.r_state !== STALL) begin errors++; $display("FAIL stall_state got %0d exp %0d", dut.r_state, STALL); end
        checks++; if (out_data !== R1) begin errors++; $display("FAIL stall_hold_a got %h exp %h", out_data, R1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", busy); end
        step(); step();
        checks++; if (dut.r_state !== STALL) begin errors++; $display("FAIL stall_state2 got %0d exp %0d", dut.r_state, STALL); end
        checks++; if (fft_x !== D2) begin errors++; $display("FAIL stall_x_held got %h exp %h", fft_x, D2); end
        checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt_a got %0d exp 4", frame_cnt); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_ov_b got %b exp 1", out_valid); end
        checks++; if (out_data !== R2) begin errors++; $display("FAIL stall_data_b got %h exp %h", out_data, R2); end
        checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt_b got %0d exp 5", frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", busy); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_ov_clear got %b exp 0", out_valid); end
    endtask

    task automatic test_gap();
        in_valid2 = 1'b1; in_data2 = D1; out_ready2 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (in_ready2 !== ((c % 5) == 0)) begin
                errors++; $display("FAIL gap_ready c=%0d got %b exp %b", c, in_ready2, ((c % 5) == 0));
            end
            checks++;
            if (fft_next2 !== ((c % 5) == 1)) begin
                errors++; $display("FAIL gap_next c=%0d got %b exp %b", c, fft_next2, ((c % 5) == 1));
            end
            step();
        end
        in_valid2 = 1'b0;
    endtask

    task automatic test_reset_midframe();
        in_valid = 1'b1; in_data = D1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; rst_n = 1'b0;
        checks++; if (fft_next !== 1'b1) begin errors++; $display("FAIL rstmid_accept got %b exp 1", fft_next); end
        step();
        rst_n = 1'b1;
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ov c=%0d got %b exp 0", c, out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready c=%0d got %b exp 1", c, in_ready); end
        end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt_end got %0d exp 0", frame_cnt); end
    endtask

    task automatic test_wrap();
        force dut.r_frame_cnt = 16'hFFFF;
        in_valid = 1'b1; in_data = D1; out_ready = 1'b1;
        step();
        release dut.r_frame_cnt;
        in_valid = 1'b0;
        step(); step();
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt got %h exp 0000", frame_cnt); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_ov got %b exp 1", out_valid); end
        checks++; if (out_data !== R1) begin errors++; $display("FAIL wrap_data got %h exp %h", out_data, R1); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_gap();
        test_reset_midframe();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
